// File: rtl/bram_readout.sv
// Read-side controller for the capture buffer: walks BRAM from a start
// address with wrap, absorbs read latency, streams over valid/ready.
module bram_readout #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_ONE   = 1;
    localparam logic [ADDR_W-1:0] L_AONE  = 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_rem;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_d0;
    logic [DATA_W-1:0]   r_d1;
    logic                r_l0;
    logic                r_l1;
    logic [1:0]          r_occ;
    logic                r_done;

    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_accept;
    logic                w_zero_req;
    logic                w_last_acc;
    logic [2:0]          w_level;

    assign w_pop      = (r_occ != 2'd0) && out_ready;
    assign w_push     = r_inflight;
    assign w_accept   = (r_state == S_IDLE) && start && !abort
                        && (count != '0);
    assign w_zero_req = (r_state == S_IDLE) && start && !abort
                        && (count == '0);
    assign w_last_acc = (r_state == S_RUN) && !abort && w_pop && r_l0;

    // Slots committed after this edge: buffered + landing - leaving.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight}
                   - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_issue = (r_rem != '0) && (w_level < 3'd2);
                    if (w_pop && r_l0) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == L_ONE);
            r_done          <= w_last_acc || w_zero_req;
            if (abort) begin
                r_rem <= '0;
            end else if (w_accept) begin
                r_addr <= start_addr;
                r_rem  <= (count > L_DEPTH) ? L_DEPTH : count;
            end else if (w_issue) begin
                r_rem <= r_rem - L_ONE;
                // Final read leaves the address parked on itself.
                if (r_rem != L_ONE) r_addr <= r_addr + L_AONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_l0  <= 1'b0;
            r_l1  <= 1'b0;
            r_occ <= 2'd0;
        end else if (abort) begin
            r_occ <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_d0 <= bram_data;
                        r_l0 <= r_inflight_last;
                    end else begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        r_d1 <= bram_data;
                        r_l1 <= r_inflight_last;
                    end
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_d0 <= bram_data;
                        r_l0 <= r_inflight_last;
                    end else begin
                        r_d1 <= bram_data;
                        r_l1 <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_occ <= r_occ - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign bram_en   = w_issue;
    assign bram_we   = 1'b0;
    assign bram_addr = r_addr;
    assign out_data  = r_d0;
    assign out_valid = (r_occ != 2'd0);
    assign out_last  = out_valid && r_l0;

endmodule

// File: tb/tb_bram_readout.sv
// Scoreboard bench for bram_readout: directed runs, monitor pops
// expected addresses and bytes as the DUT presents them.
module tb_bram_readout;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          abort;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [7:0]    mem [0:2047];
    logic [8:0]    q_data [$];
    logic [10:0]   q_addr [$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    bram_readout dut (
        .CLK(CLK), .RST_N(RST_N), .start(start),
        .start_addr(start_addr), .count(count), .abort(abort),
        .busy(busy), .done(done), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_data(bram_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < 2048; i++) mem[i] = i[7:0];

    always @(posedge CLK) if (bram_en) bram_data <= mem[bram_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h",
                     nm, act, exp);
        end
    endtask

    task automatic fail_extra(input string nm, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=0x%0h required=none", nm, act);
    endtask

    logic       m_stall = 1'b0;
    logic [7:0] m_data  = '0;
    logic       m_lastacc = 1'b0;

    always @(negedge CLK) begin
        chk("bram_we", bram_we, 0);
        if (!RST_N || abort) begin
            m_stall   = 1'b0;
            m_lastacc = 1'b0;
            q_addr.delete();
            q_data.delete();
        end else begin
            if (m_lastacc) chk("done_after_last", done, 1);
            if (done) done_cnt++;
            if (m_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, m_data);
            end
            if (bram_en) begin
                if (q_addr.size() == 0) fail_extra("extra_read", bram_addr);
                else chk("read_addr", bram_addr, q_addr.pop_front());
            end
            if (out_valid && out_ready) begin
                if (q_data.size() == 0)
                    fail_extra("extra_byte", {out_last, out_data});
                else
                    chk("out_byte", {out_last, out_data}, q_data.pop_front());
            end
            m_stall   = out_valid && !out_ready;
            m_data    = out_data;
            m_lastacc = out_valid && out_ready && out_last;
        end
    end

    task automatic expect_run(input logic [10:0] a, input int n);
        logic [10:0] ad;
        int m;
        m = (n > 2048) ? 2048 : n;
        for (int i = 0; i < m; i++) begin
            ad = a + 11'(i);
            q_addr.push_back(ad);
            q_data.push_back({(i == m - 1), ad[7:0]});
        end
    endtask

    task automatic go(input logic [10:0] a, input logic [11:0] n);
        start      = 1'b1;
        start_addr = a;
        count      = n;
        @(posedge CLK); #1;
        start      = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int bound);
        int c;
        c = 0;
        while ((q_data.size() != 0 || busy) && c < bound) begin
            @(posedge CLK); #1;
            c++;
        end
        chk(nm, (c >= bound), 0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    logic [39:0] pat;
    int d0;
    int c;

    initial begin
        RST_N = 1'b0; start = 1'b0; start_addr = '0; count = '0;
        abort = 1'b0; out_ready = 1'b1;
        pat = 40'b1110_0000_1011_0111_1100_0001_1010_0111_1101_1011;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        d0 = done_cnt;
        expect_run(11'h010, 4);
        go(11'h010, 12'd4);
        chk("t1_busy", busy, 1);
        chk("t1_en", bram_en, 1);
        chk("t1_addr", bram_addr, 11'h010);
        chk("t1_valid_e0", out_valid, 0);
        @(posedge CLK); #1;
        chk("t1_valid_e1", out_valid, 0);
        @(posedge CLK); #1;
        chk("t1_valid_e2", out_valid, 1);
        chk("t1_data_e2", out_data, 8'h10);
        chk("t1_last_e2", out_last, 0);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("t1_stream", out_valid, 1);
        end
        chk("t1_last_data", out_data, 8'h13);
        chk("t1_last", out_last, 1);
        @(posedge CLK); #1;
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", out_valid, 0);
        @(posedge CLK); #1;
        chk("t1_done_pulse", done, 0);
        chk("t1_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h7FE, 4);
        go(11'h7FE, 12'd4);
        wait_drain("wrap_timeout", 50);
        chk("wrap_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h0A0, 16);
        go(11'h0A0, 12'd16);
        c = 0;
        while ((q_data.size() != 0 || busy) && c < 300) begin
            out_ready = pat[c % 40];
            start = (c == 4);
            start_addr = 11'h500;
            count = 12'd5;
            @(posedge CLK); #1;
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("bp_timeout", (c >= 300), 0);
        @(posedge CLK); #1;
        chk("bp_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        go(11'h300, 12'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_en", bram_en, 0);
        @(posedge CLK); #1;
        chk("zero_done_pulse", done, 0);
        chk("zero_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h400, 2048);
        go(11'h400, 12'd2048);
        wait_drain("full_timeout", 2200);
        chk("full_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h7F0, 4095);
        go(11'h7F0, 12'hFFF);
        wait_drain("clamp_timeout", 2200);
        chk("clamp_done_cnt", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h050, 10);
        go(11'h050, 12'd10);
        c = 0;
        while (q_data.size() > 7 && c < 50) begin
            @(posedge CLK); #1;
            c++;
        end
        out_ready = 1'b0;
        chk("ab_three_bytes", q_data.size(), 7);
        repeat (4) @(posedge CLK);
        #1;
        chk("ab_stall_valid", out_valid, 1);
        chk("ab_stall_busy", busy, 1);
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        chk("ab_valid", out_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_en", bram_en, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("ab_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        d0 = done_cnt;
        expect_run(11'h123, 3);
        go(11'h123, 12'd3);
        wait_drain("ab_restart_timeout", 50);
        chk("ab_restart_done", done_cnt - d0, 1);

        d0 = done_cnt;
        expect_run(11'h200, 10);
        go(11'h200, 12'd10);
        repeat (4) @(posedge CLK);
        #2;
        q_addr.delete();
        q_data.delete();
        RST_N = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_en", bram_en, 0);
        chk("mr_last", out_last, 0);
        chk("mr_done", done, 0);
        @(posedge CLK); #1;
        go(11'h111, 12'd5);
        chk("mr_start_busy", busy, 0);
        chk("mr_start_en", bram_en, 0);
        chk("mr_start_valid", out_valid, 0);
        #3;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("mr_after_busy", busy, 0);
        chk("mr_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        expect_run(11'h7FF, 2);
        go(11'h7FF, 12'd2);
        wait_drain("post_rst_timeout", 50);
        chk("post_rst_done", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_readout.md
Name: bram_readout

Overview:
- Read-side controller for the 2K x 8 capture buffer.
- After a capture completes, it walks the buffer from a given start address for a given number of samples, wrapping at the top.
- It drives the buffer's port (EN/WE/ADDR) and absorbs the one-cycle registered read latency.
- It streams bytes out over a valid/ready handshake to the host-link transmitter at up to one byte per clock.

Parameters:
- ADDR_W, 11, buffer address width.
- DATA_W, 8, sample width.
- DEPTH, 2048, buffer depth (2**ADDR_W).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a readout; ignored while busy.
- start_addr  in  ADDR_W  first address read; sampled with start.
- count  in  ADDR_W+1  number of bytes to read; sampled with start.
- abort  in  1  synchronous cancel of the current readout.
- busy  out  1  high from the cycle after an accepted start until done/abort.
- done  out  1  one-cycle pulse when the last byte is accepted downstream.
- bram_en  out  1  buffer enable, to BRAM EN.
- bram_we  out  1  buffer write enable; constant 0.
- bram_addr  out  ADDR_W  buffer address.
- bram_data  in  DATA_W  buffer read data (BRAM data_out).
- out_data  out  DATA_W  stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when valid&ready at a rising edge.
- out_last  out  1  high with the final byte of the readout.

Behaviour:
- Reset (RST_N=0, asynchronous): all outputs 0, internal counters and buffer cleared, state IDLE. Deassertion takes effect at the first rising edge after release.
- BRAM timing: EN/ADDR presented in cycle n are sampled at edge n+1. bram_data is valid from just after edge n+1 and is captured at edge n+2. bram_data holds while EN=0; the controller never relies on the held value.
- States:
  - IDLE: start=1 with count in 1..DEPTH → latch addr and count, go to RUN, busy=1. count=0 → no reads, done pulses in the next cycle, stay IDLE. count>DEPTH → clamp to DEPTH.
  - RUN: issue reads and drain output. Go to IDLE in the cycle the last byte is accepted; done=1 and busy=0 in the following cycle.
- Output buffer: 2-entry skid FIFO.
  - A read is issued in a cycle only if (fifo occupancy + reads in flight − pop this cycle) < 2 and reads remaining > 0.
  - No captured byte may be dropped or duplicated under any out_ready pattern.
  - out_data/out_valid come directly from the FIFO head register.
  - out_valid, once high, stays high with stable out_data until accepted.
- Throughput: with out_ready held high, one byte per cycle after initial latency.
- Latency: start sampled at edge E0 → bram_en=1, bram_addr=start_addr during E0..E1 → out_valid=1 from E2.
- Address arithmetic: increment per issued read modulo DEPTH (2047 → 0). Remaining count decrements per issued read.
- out_last is asserted with the byte whose issue brought remaining to 0.
- bram_en is 0 whenever no read is issued. bram_addr holds its last value when idle.
- abort=1 (any state): next edge forces IDLE, flushes the FIFO, discards in-flight data. out_valid=0, busy=0, no done.
- abort has priority over start in the same cycle.
- start while busy: ignored; latched parameters unchanged.
- Reset mid-readout: same as reset; no done.

Test Plan:
- Fill mem[i]=i[7:0]; start_addr=0x010, count=4, out_ready=1 → bytes 0x10,0x11,0x12,0x13 on consecutive cycles; out_valid rises 2 edges after start; out_last on 0x13; done one cycle later.
- Wrap: start_addr=0x7FE, count=4 → addresses 0x7FE,0x7FF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
- Backpressure: count=16, out_ready toggling randomly (including 5-cycle stalls) → exactly 16 bytes in order, no gaps/duplicates; out_data stable while valid&!ready.
- Full buffer: count=0 → 2048 reads? No: count=0 → done pulse next cycle, bram_en never asserted. count=2048 from 0x400 → 2048 bytes, last byte 0xFF (addr 0x3FF), done asserted.
- Abort after 3 bytes of a count=10 run with out_ready=0 → out_valid=0 and busy=0 after next edge, no done; a new start then reads correctly from its own start_addr.
- Async reset asserted mid-run between edges → outputs 0 immediately; start ignored until reset released; bram_we always 0.
